irq_event_capture_18: RTL and testbench
=======================================

Name: irq_event_capture_18

Overview:
- Captures 18 external or peripheral event lines into per-source pending bits.
- Masks the pending bits and drives them onto the 18 inputs of the downstream 18-input OR gate, which produces the CPU's "any interrupt" line.
- Also presents the lowest-index enabled pending source as an ID with a valid/ack handshake, so the control unit knows which source to service and which bit to retire.

Parameters:
- NUM_SRC, 18, number of sources. Fixed at 18 to match the downstream OR gate; other values are unsupported.
- EDGE_MASK, 18'h3FFFF, per-source mode. Bit i = 1 means source i is edge-triggered (rising edge, latched). Bit i = 0 means source i is level-triggered (follows the synchronised input).
- ID_W, 5, width of Irq_Id.

Ports:
- Clock  in  1  system clock; all flops on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Src_In  in  18  raw event lines; may be asynchronous to Clock.
- Enable_Mask  in  18  per-source enable from the CPU control register.
- Ack  in  1  one-cycle pulse from the control unit: the presented ID is serviced.
- Pending  out  18  Pend_q & Enable_Mask. Bit i feeds Input_(i+1) of the OR gate.
- Irq_Valid  out  1  Irq_Id is valid.
- Irq_Id  out  5  index 0..17 of the presented source.

Behaviour:
- Reset asserted (low), asynchronous:
  - sync1/sync2/prev registers, Pend_q, Irq_Id = 0, Irq_Valid = 0, FSM = IDLE.
  - Outputs are 0 while Reset is held low.
  - Reset mid-handshake discards the presented ID and all pending bits.
- Synchroniser: a two-flop chain per source (sync1 -> sync2), then a prev register holding the previous sync2.
- Edge source i:
  - set_i = sync2[i] & ~prev[i].
  - Pend_q[i] sets on set_i.
  - Pend_q[i] clears only in the CLEAR state when Irq_Id == i.
  - Set and clear in the same cycle: set wins and the bit stays 1, so no event is lost.
- Level source i:
  - Pend_q[i] = sync2[i] every cycle; Ack has no effect.
  - If the line is still high after service, the source re-presents.
- Latency, edge source: Src_In rises before edge E0; sync1 at E0, sync2 at E1, Pend_q at E2. Pending is visible after E2 and Irq_Valid after E3.
- Latency, level source: Pend_q after E1, Irq_Valid after E2.
- Masking:
  - Enable_Mask does not block latching; a disabled edge event stays latched in Pend_q.
  - That event appears on Pending as soon as its enable bit is set.
- Priority: the lowest set index of (Pend_q & Enable_Mask) wins.
- FSM (2-bit state encoding):
  - IDLE: Irq_Valid = 0. If (Pend_q & Enable_Mask) != 0, latch the winner into Irq_Id and go to PRESENT.
  - PRESENT: Irq_Valid = 1 and Irq_Id is held stable. A change in Enable_Mask or a new higher-priority event does not change Irq_Id. On Ack go to CLEAR.
  - CLEAR: one cycle, Irq_Valid = 0. The edge bit Irq_Id is cleared. Then go to IDLE.
  - Minimum gap between two presentations is 2 cycles (CLEAR, then IDLE evaluates).
- Ack outside PRESENT is ignored.
- Presented source disabled while in PRESENT: it is still presented until Ack, and its edge bit is cleared on Ack.
- Irq_Id is registered and keeps its last value after CLEAR; it is don't-care when Irq_Valid = 0. Irq_Valid is registered.
- Pending is combinational from Pend_q and Enable_Mask.

Decomposition:
- Shared package:
  - FSM state encodings: IDLE = 2'd0, PRESENT = 2'd1, CLEAR = 2'd2.
  - NUM_SRC = 18 and ID_W = 5 constants.
- One sub-module: irq_prio_enc_18, a combinational 18-to-5 lowest-index priority encoder with an "any" output. It is reusable by other controllers.
- Synchroniser, edge detection and FSM stay in this block.

Test Plan:
- Reset low with all Src_In = 1 -> Pending = 0, Irq_Valid = 0. Release reset and pulse Src_In[3] (edge mode, enabled) -> Pending = 18'h00008 after E2, Irq_Valid = 1 with Irq_Id = 3 after E3. Ack -> Pending = 0 two cycles later.
- Src_In[7] and Src_In[2] rise together, both enabled -> Irq_Id = 2 first. Ack -> CLEAR -> Irq_Id = 7. Ack again -> idle, Pending = 0.
- Source 5 disabled, edge on Src_In[5] -> Pending = 0 and Irq_Valid = 0. Set Enable_Mask[5] -> Pending[5] = 1 the same cycle, Irq_Id = 5 one cycle later.
- EDGE_MASK[9] = 0 with Src_In[9] held high across Ack -> Irq_Id = 9 again 2 cycles after Ack. Drop Src_In[9] -> Pending[9] = 0 after 2 cycles.
- Second rising edge on Src_In[4] timed so set_4 coincides with CLEAR for Id 4 -> Pend_q[4] stays 1 and Id 4 re-presents. Ack pulse while in IDLE -> no state change.
- Assert Reset low while in PRESENT with 3 bits pending -> Irq_Valid and Pending = 0 immediately without a clock. After release, no presentation occurs until new edges arrive.

Source files
------------

// File: rtl/irq_event_capture_18_pkg.sv
// ---------------------------------------------------------------------------
// irq_event_capture_18_pkg
// Shared constants and FSM state encoding for the 18-source interrupt
// event capture block and its lowest-index priority encoder.
//   NUM_SRC     : number of event sources (tied to the downstream 18-input OR)
//   ID_W        : width of the presented source index
//   irq_state_e : handshake FSM states (IDLE / PRESENT / CLEAR)
// ---------------------------------------------------------------------------
package irq_event_capture_18_pkg;

   localparam int NUM_SRC = 18;
   localparam int ID_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_CLEAR   = 2'd2
   } irq_state_e;

endpackage : irq_event_capture_18_pkg

// File: rtl/irq_event_capture_18_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc_18
// Combinational 18-to-5 priority encoder; the lowest set index wins.
// Ports:
//   req_i [17:0] : request vector
//   id_o  [4:0]  : index of the lowest set request (0 when none set)
//   any_o        : at least one request is set
// ---------------------------------------------------------------------------
module irq_prio_enc_18
   import irq_event_capture_18_pkg::*;
(
   input  logic [NUM_SRC-1:0] req_i,
   output logic [ID_W-1:0]    id_o,
   output logic               any_o
);

   // Scan from the top index down so the lowest set index is written last.
   always_comb begin
      id_o = {ID_W{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         id_o = req_i[i] ? ID_W'(i) : id_o;
      end
   end

   assign any_o = |req_i;

endmodule : irq_prio_enc_18

// File: rtl/irq_event_capture_18.sv
// ---------------------------------------------------------------------------
// irq_event_capture_18
// Captures 18 event lines into pending bits, drives the masked pending
// vector to the downstream 18-input OR gate and presents the lowest-index
// enabled pending source with a valid/ack handshake.
// Ports:
//   Clock             : system clock, rising edge
//   Reset             : asynchronous active-low reset
//   Src_In      [17:0]: raw event lines, may be asynchronous to Clock
//   Enable_Mask [17:0]: per-source enable
//   Ack               : one-cycle pulse, presented ID has been serviced
//   Pending     [17:0]: pending & enable, bit i feeds OR-gate input i+1
//   Irq_Valid         : Irq_Id is valid
//   Irq_Id      [4:0] : index of the presented source
// Parameter:
//   EDGE_MASK : bit i = 1 -> source i rising-edge latched, 0 -> level
// ---------------------------------------------------------------------------
module irq_event_capture_18
   import irq_event_capture_18_pkg::*;
#(
   parameter logic [NUM_SRC-1:0] EDGE_MASK = 18'h3FFFF
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [NUM_SRC-1:0] Src_In,
   input  logic [NUM_SRC-1:0] Enable_Mask,
   input  logic               Ack,
   output logic [NUM_SRC-1:0] Pending,
   output logic               Irq_Valid,
   output logic [ID_W-1:0]    Irq_Id
);

   logic [NUM_SRC-1:0] sync1_q;
   logic [NUM_SRC-1:0] sync2_q;
   logic [NUM_SRC-1:0] prev_q;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] set_s;
   logic [NUM_SRC-1:0] clr_s;
   logic [NUM_SRC-1:0] enabled_s;
   logic [ID_W-1:0]    win_id_s;
   logic               win_any_s;
   logic [ID_W-1:0]    irq_id_q;
   logic               irq_valid_q;
   irq_state_e         state_q;

   assign set_s     = sync2_q & ~prev_q;
   assign enabled_s = pend_q & Enable_Mask;

   // One-hot retire vector for the presented source while in CLEAR.
   always_comb begin
      clr_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_s[i] = (state_q == ST_CLEAR) && (irq_id_q == ID_W'(i));
      end
   end

   // Next pending state. Edge bits: a new set beats a same-cycle clear so
   // no event is lost. Level bits load sync1 so pend_q equals sync2 in the
   // same cycle, i.e. pend_q mirrors the synchronised line directly.
   always_comb begin
      pend_d = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         pend_d[i] = EDGE_MASK[i] ? (set_s[i] | (pend_q[i] & ~clr_s[i]))
                                  : sync1_q[i];
      end
   end

   // Synchroniser chain, edge-detect history and pending register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_q <= {NUM_SRC{1'b0}};
         sync2_q <= {NUM_SRC{1'b0}};
         prev_q  <= {NUM_SRC{1'b0}};
         pend_q  <= {NUM_SRC{1'b0}};
      end else begin
         sync1_q <= Src_In;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pend_q  <= pend_d;
      end
   end

   irq_prio_enc_18 u_prio_enc (
      .req_i (enabled_s),
      .id_o  (win_id_s),
      .any_o (win_any_s)
   );

   // Handshake FSM: the ID is latched on entry to PRESENT and held until Ack,
   // regardless of later mask changes or higher-priority arrivals.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         irq_id_q    <= {ID_W{1'b0}};
         irq_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_any_s) begin
                  irq_id_q    <= win_id_s;
                  irq_valid_q <= 1'b1;
                  state_q     <= ST_PRESENT;
               end else begin
                  irq_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            ST_PRESENT: begin
               if (Ack) begin
                  irq_valid_q <= 1'b0;
                  state_q     <= ST_CLEAR;
               end else begin
                  irq_valid_q <= 1'b1;
                  state_q     <= ST_PRESENT;
               end
            end
            ST_CLEAR: begin
               irq_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               irq_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign Pending   = enabled_s;
   assign Irq_Valid = irq_valid_q;
   assign Irq_Id    = irq_id_q;

endmodule : irq_event_capture_18

// File: tb/tb_irq_event_capture_18.sv
// ---------------------------------------------------------------------------
// tb_irq_event_capture_18
// Directed scenarios followed by randomized traffic. Expected outputs come
// from a behavioural model that works from the input history (how the line
// looked N clock edges ago) and a simple service phase.
// Sources 9 and 12 are level-triggered, all others edge-triggered.
// ---------------------------------------------------------------------------
module tb_irq_event_capture_18;

   localparam logic [17:0] EM = 18'h3EDFF;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [17:0] Src_In;
   logic [17:0] Enable_Mask;
   logic        Ack;
   logic [17:0] Pending;
   logic        Irq_Valid;
   logic [4:0]  Irq_Id;

   always #5 Clock = ~Clock;

   irq_event_capture_18 #(.EDGE_MASK(EM)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Src_In      (Src_In),
      .Enable_Mask (Enable_Mask),
      .Ack         (Ack),
      .Pending     (Pending),
      .Irq_Valid   (Irq_Valid),
      .Irq_Id      (Irq_Id)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [17:0] samp [0:2];   // samp[k]: Src_In as sampled k+1 edges ago
   logic [17:0] m_pend;
   int          m_phase;      // 0 waiting, 1 presenting, 2 retiring
   int          m_id;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) samp[k] = 18'h0;
      m_pend  = 18'h0;
      m_phase = 0;
      m_id    = 0;
   endtask

   task automatic model_edge();
      logic [17:0] en_p;
      logic [17:0] nxt;
      int          win;
      if (!Reset) begin
         model_reset();
         return;
      end
      en_p = m_pend & Enable_Mask;
      win  = -1;
      for (int i = 0; i < 18; i++) if (en_p[i] && win < 0) win = i;
      for (int i = 0; i < 18; i++) begin
         if (EM[i])
            // rising edge: line high 2 samples back, low 3 samples back
            nxt[i] = (samp[1][i] & ~samp[2][i]) |
                     (m_pend[i] & !(m_phase == 2 && m_id == i));
         else
            nxt[i] = samp[0][i];
      end
      case (m_phase)
         0: if (win >= 0) begin m_id = win; m_phase = 1; end
         1: if (Ack) m_phase = 2;
         2: m_phase = 0;
         default: m_phase = 0;
      endcase
      m_pend  = nxt;
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = Src_In;
   endtask

   task automatic check_model();
      chk("pending", 32'(Pending), 32'(m_pend & Enable_Mask));
      chk("valid", 32'(Irq_Valid), 32'(m_phase == 1));
      if (m_phase == 1) chk("id", 32'(Irq_Id), 32'(m_id));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clock);
         model_edge();
         @(negedge Clock);
         check_model();
      end
   endtask

   task automatic ack_pulse();
      Ack = 1'b1;
      step(1);
      Ack = 1'b0;
   endtask

   initial begin
      Reset       = 1'b0;
      Ack         = 1'b0;
      Src_In      = 18'h3FFFF;
      Enable_Mask = 18'h3FFFF;
      model_reset();

      // reset state with all lines high
      #12;
      chk("rst_pending", 32'(Pending), 32'h0);
      chk("rst_valid", 32'(Irq_Valid), 32'h0);
      Src_In = 18'h0;
      Reset  = 1'b1;
      step(2);

      // single edge on source 3
      Src_In[3] = 1'b1;
      step(1);
      Src_In[3] = 1'b0;
      step(1);
      step(1);
      chk("s3_pending_e2", 32'(Pending), 32'h8);
      chk("s3_valid_e2", 32'(Irq_Valid), 32'h0);
      step(1);
      chk("s3_valid_e3", 32'(Irq_Valid), 32'h1);
      chk("s3_id", 32'(Irq_Id), 32'd3);
      ack_pulse();
      step(1);
      chk("s3_cleared", 32'(Pending), 32'h0);

      // simultaneous 2 and 7: lowest first
      Src_In[7] = 1'b1;
      Src_In[2] = 1'b1;
      step(4);
      chk("pri_first", 32'(Irq_Id), 32'd2);
      ack_pulse();
      step(2);
      chk("pri_second_v", 32'(Irq_Valid), 32'h1);
      chk("pri_second", 32'(Irq_Id), 32'd7);
      ack_pulse();
      step(1);
      chk("pri_done", 32'(Pending), 32'h0);
      Src_In = 18'h0;
      step(3);

      // disabled edge stays latched, shows up once enabled
      Enable_Mask[5] = 1'b0;
      Src_In[5]      = 1'b1;
      step(5);
      chk("mask_pending", 32'(Pending), 32'h0);
      chk("mask_valid", 32'(Irq_Valid), 32'h0);
      Enable_Mask[5] = 1'b1;
      #1;
      chk("unmask_pending", 32'(Pending), 32'h20);
      step(1);
      chk("unmask_id", 32'(Irq_Id), 32'd5);
      ack_pulse();
      step(1);
      Src_In[5] = 1'b0;
      step(2);

      // level source 9 re-presents while held high
      Src_In[9] = 1'b1;
      step(3);
      chk("lvl_id", 32'(Irq_Id), 32'd9);
      ack_pulse();
      step(2);
      chk("lvl_repr_v", 32'(Irq_Valid), 32'h1);
      chk("lvl_repr_id", 32'(Irq_Id), 32'd9);
      Src_In[9] = 1'b0;
      step(2);
      chk("lvl_drop", 32'(Pending & 18'h200), 32'h0);
      ack_pulse();
      step(2);

      // second edge on 4 coincides with its CLEAR: set wins
      Src_In[4] = 1'b1;
      step(1);
      Src_In[4] = 1'b0;
      step(3);
      chk("e4_first", 32'(Irq_Id), 32'd4);
      Src_In[4] = 1'b1;
      step(1);
      Ack = 1'b1;
      step(1);
      Ack = 1'b0;
      step(1);
      chk("e4_kept", 32'(Pending & 18'h10), 32'h10);
      step(1);
      chk("e4_repr_v", 32'(Irq_Valid), 32'h1);
      chk("e4_repr_id", 32'(Irq_Id), 32'd4);
      ack_pulse();
      step(1);
      Src_In[4] = 1'b0;
      step(2);
      Ack = 1'b1;
      step(1);
      Ack = 1'b0;
      chk("idle_ack_v", 32'(Irq_Valid), 32'h0);
      chk("idle_ack_p", 32'(Pending), 32'h0);
      step(1);

      // asynchronous reset in PRESENT with three bits pending
      Src_In[1]  = 1'b1;
      Src_In[6]  = 1'b1;
      Src_In[11] = 1'b1;
      step(4);
      chk("pre_rst_id", 32'(Irq_Id), 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      chk("async_rst_v", 32'(Irq_Valid), 32'h0);
      chk("async_rst_p", 32'(Pending), 32'h0);
      model_reset();
      Src_In = 18'h0;
      step(2);
      Reset = 1'b1;
      step(6);
      chk("post_rst_v", 32'(Irq_Valid), 32'h0);

      // randomized traffic
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 18; b++)
            if ($urandom_range(15) == 0) Src_In[b] = ~Src_In[b];
         if ($urandom_range(19) == 0) Enable_Mask = 18'($urandom);
         if (m_phase == 1) Ack = ($urandom_range(2) == 0);
         else              Ack = ($urandom_range(19) == 0);
         Reset = ($urandom_range(499) != 0);
         step(1);
      end
      Ack   = 1'b0;
      Reset = 1'b1;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_irq_event_capture_18
